// File: rtl/gpu_draw_pkg.sv
// Shared definitions for the triangle job scheduler: command layout, FSM encoding, colour width.
package gpu_draw_pkg;

  localparam int COLW     = 24;
  localparam int FILL_OFS = COLW;
  localparam int VTX_BASE = COLW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_RELEASE = 2'b10
  } sched_state_t;

  function automatic int cmd_w(input int cordw);
    return 6 * cordw + VTX_BASE;
  endfunction

  // Vertex fields 0..5 are x0,y0,x1,y1,x2,y2; x0 sits in the most significant slot.
  function automatic int vtx_ofs(input int cordw, input int idx);
    return VTX_BASE + (5 - idx) * cordw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from the index after last_grant, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [TAGW-1:0] grant_idx,
  output logic            found
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        grant_idx    = TAGW'(idx);
      end
    end
  end

endmodule

// File: rtl/triangle_job_scheduler.sv
// Shares one triangle rasterizer between NREQ command sources, forwards its pixels tagged
// with the owner, and reports per-job completion with a pixel count.
module triangle_job_scheduler
  import gpu_draw_pkg::*;
#(
  parameter  int CORDW = 8,
  parameter  int NREQ  = 2,
  localparam int TAGW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CMDW  = cmd_w(CORDW),
  localparam int CNTW  = 2 * CORDW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0][CMDW-1:0] req_cmd,
  output logic [NREQ-1:0]           ack,
  output logic                      cmpl,
  output logic [TAGW-1:0]           cmpl_tag,
  output logic [CNTW-1:0]           cmpl_pixels,
  output logic                      busy,
  output logic                      rast_start,
  output logic [CORDW-1:0]          rast_x0,
  output logic [CORDW-1:0]          rast_y0,
  output logic [CORDW-1:0]          rast_x1,
  output logic [CORDW-1:0]          rast_y1,
  output logic [CORDW-1:0]          rast_x2,
  output logic [CORDW-1:0]          rast_y2,
  output logic                      rast_fill,
  output logic [COLW-1:0]           rast_color,
  input  logic                      rast_valid,
  input  logic [CORDW-1:0]          rast_px,
  input  logic [CORDW-1:0]          rast_py,
  input  logic [COLW-1:0]           rast_color_in,
  input  logic                      rast_done,
  output logic                      fb_we,
  output logic [CORDW-1:0]          fb_x,
  output logic [CORDW-1:0]          fb_y,
  output logic [COLW-1:0]           fb_color,
  output logic [TAGW-1:0]           fb_tag
);

  sched_state_t    state, state_nxt;
  logic [TAGW-1:0] last_grant, cur_tag, win_idx;
  logic [NREQ-1:0] win_grant;
  logic            win_found;
  logic            take, finish;
  logic [CMDW-1:0] win_cmd;
  logic [CNTW-1:0] pix_cnt, pix_cnt_nxt;

  rr_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) u_arb (
    .req       (req),
    .last_grant(last_grant),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .found     (win_found)
  );

  assign win_cmd     = req_cmd[win_idx];
  assign pix_cnt_nxt = pix_cnt + CNTW'(rast_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (win_found) begin
        take      = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: if (rast_done) begin
        finish    = 1'b1;
        state_nxt = ST_RELEASE;
      end
      // Wait out the rasterizer's trailing done so it is not mistaken for the next job's.
      ST_RELEASE: if (!rast_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= TAGW'(NREQ - 1);
      cur_tag     <= '0;
      pix_cnt     <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      cmpl        <= 1'b0;
      cmpl_tag    <= '0;
      cmpl_pixels <= '0;
      rast_start  <= 1'b0;
      rast_x0     <= '0;
      rast_y0     <= '0;
      rast_x1     <= '0;
      rast_y1     <= '0;
      rast_x2     <= '0;
      rast_y2     <= '0;
      rast_fill   <= 1'b0;
      rast_color  <= '0;
      fb_we       <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_color    <= '0;
      fb_tag      <= '0;
    end else begin
      ack   <= take ? win_grant : '0;
      busy  <= (state_nxt != ST_IDLE);
      cmpl  <= finish;
      fb_we <= rast_valid;

      if (take) begin
        cur_tag    <= win_idx;
        last_grant <= win_idx;
        pix_cnt    <= '0;
        rast_start <= 1'b1;
        rast_x0    <= win_cmd[vtx_ofs(CORDW, 0) +: CORDW];
        rast_y0    <= win_cmd[vtx_ofs(CORDW, 1) +: CORDW];
        rast_x1    <= win_cmd[vtx_ofs(CORDW, 2) +: CORDW];
        rast_y1    <= win_cmd[vtx_ofs(CORDW, 3) +: CORDW];
        rast_x2    <= win_cmd[vtx_ofs(CORDW, 4) +: CORDW];
        rast_y2    <= win_cmd[vtx_ofs(CORDW, 5) +: CORDW];
        rast_fill  <= win_cmd[FILL_OFS];
        rast_color <= win_cmd[COLW-1:0];
      end else begin
        pix_cnt <= pix_cnt_nxt;
      end

      // The final count includes a pixel arriving alongside done.
      if (finish) begin
        rast_start  <= 1'b0;
        cmpl_tag    <= cur_tag;
        cmpl_pixels <= pix_cnt_nxt;
      end

      if (rast_valid) begin
        fb_x     <= rast_px;
        fb_y     <= rast_py;
        fb_color <= rast_color_in;
        fb_tag   <= cur_tag;
      end
    end
  end

endmodule
